score_text_scheduler: RTL and testbench

- Sequences score-to-text conversion for two players and writes the result into the shared character buffer used by the text overlay.
- Watches both 8-bit score inputs and detects changes. Arbitrates round-robin between the two players.
- Converts one score at a time with an iterative subtract-by-10 divider.
- Emits two ASCII characters per score (tens, ones) over a valid/ready write port.

---
 rtl/score_text_pkg.sv | 32 +++
 rtl/score_text_scheduler_div10.sv | 56 +++++
 rtl/score_text_scheduler.sv | 161 ++++++++++++++++
 tb/tb_score_text_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_text_pkg.sv
// Shared definitions for the score-to-text scheduler.
// Contents: FSM state encoding, player-select constants, ASCII constants
// and small helpers used by the top and the divider datapath.
package score_text_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DIV     = 3'd2,
    WR_TENS = 3'd3,
    WR_ONES = 3'd4
  } state_t;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_DASH  = 7'h2D;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

  // Largest score that still fits in two decimal digits.
  localparam logic [7:0] SCORE_MAX = 8'd99;

  function automatic logic score_ovf(input logic [7:0] v);
    return v > SCORE_MAX;
  endfunction

  function automatic logic [6:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/score_text_scheduler_div10.sv
// score_div10_iter: iterative subtract-by-10 divider for one 8-bit score.
// Ports:
//   clk, rst  clock, synchronous active-high reset (control state only)
//   start     1-cycle pulse: capture value, clear the tens count
//   value     unsigned score to convert
//   done      high while the remainder is below 10 and a conversion is running
//   tens      quotient (tens digit)
//   ones      remainder (ones digit)
//   ovf       captured value was above 99; no division is performed
module score_div10_iter
  import score_text_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf
);

  logic       run_p0;
  logic [7:0] cap_p0;
  logic [3:0] tens_p0;
  logic       ovf_p0;

  // Control: a conversion runs from start until the remainder drops below 10.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_p0 <= 1'b0;
    end else if (start) begin
      run_p0 <= !score_ovf(value);
    end else if (run_p0 && (cap_p0 < 8'd10)) begin
      run_p0 <= 1'b0;
    end
  end

  // Datapath: one subtraction per cycle while the remainder is at least 10.
  always_ff @(posedge clk) begin
    if (start) begin
      cap_p0  <= value;
      tens_p0 <= 4'd0;
      ovf_p0  <= score_ovf(value);
    end else if (run_p0 && (cap_p0 >= 8'd10)) begin
      cap_p0  <= cap_p0 - 8'd10;
      tens_p0 <= tens_p0 + 4'd1;
    end
  end

  assign done = run_p0 && (cap_p0 < 8'd10);
  assign tens = tens_p0;
  assign ones = cap_p0[3:0];
  assign ovf  = ovf_p0;

endmodule

// File: rtl/score_text_scheduler.sv
// score_text_scheduler: watches two player scores, and whenever one changes
// converts it to two ASCII characters (tens, ones) and writes them into the
// overlay character buffer over a valid/ready port.
// Optional build macro SCORE_TEXT_BLANK_LEADING_ZERO_EN: a zero tens digit
// of a score below 100 is written as a space instead of '0'.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   score_p1/p2     player scores, unsigned binary
//   wr_en           character write valid
//   wr_ready        buffer accepts when wr_en && wr_ready
//   wr_addr         character buffer address
//   wr_data         ASCII character
//   busy            high whenever the FSM is not idle
module score_text_scheduler
  import score_text_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR_P1 = 8'h00,
  parameter logic [ADDR_W-1:0] BASE_ADDR_P2 = 8'h10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        score_p1,
  input  logic [7:0]        score_p2,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ONES_OFS = ADDR_W'(1);

  state_t     state;
  logic       rr_ptr;
  logic       sel;
  logic       pend_p1, pend_p2;
  logic [7:0] last_p1, last_p2;

  logic       grant;
  logic [7:0] sel_score;
  logic [ADDR_W-1:0] base_sel;
  logic       ones_hs;

  logic       div_done;
  logic [3:0] div_tens;
  logic [3:0] div_ones;
  logic       div_ovf;

  function automatic logic [6:0] tens_char(input logic [3:0] t);
`ifdef SCORE_TEXT_BLANK_LEADING_ZERO_EN
    return (t == 4'd0) ? ASCII_SPACE : digit_char(t);
`else
    return digit_char(t);
`endif
  endfunction

  // With both players pending, the one not served last wins.
  always_comb begin
    grant = P1;
    if (pend_p1 && pend_p2) grant = ~rr_ptr;
    else if (pend_p2)       grant = P2;
  end

  assign sel_score = (sel == P2) ? score_p2 : score_p1;
  assign base_sel  = (sel == P2) ? BASE_ADDR_P2 : BASE_ADDR_P1;
  assign ones_hs   = (state == WR_ONES) && wr_en && wr_ready;

  score_div10_iter u_div (
    .clk   (clk),
    .rst   (rst),
    .start (state == LOAD),
    .value (sel_score),
    .done  (div_done),
    .tens  (div_tens),
    .ones  (div_ones),
    .ovf   (div_ovf)
  );

  // Change detector: a new score always re-pends the player, even on the
  // cycle its previous text finishes, so no update is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_p1 <= 8'hFF;
      last_p2 <= 8'hFF;
      pend_p1 <= 1'b1;
      pend_p2 <= 1'b1;
    end else begin
      if (state == LOAD && sel == P1) last_p1 <= score_p1;
      if (state == LOAD && sel == P2) last_p2 <= score_p2;

      if (score_p1 != last_p1)       pend_p1 <= 1'b1;
      else if (ones_hs && sel == P1) pend_p1 <= 1'b0;

      if (score_p2 != last_p2)       pend_p2 <= 1'b1;
      else if (ones_hs && sel == P2) pend_p2 <= 1'b0;
    end
  end

  // Sequencer with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= P1;
      sel     <= P1;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= ASCII_ZERO;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_p1 || pend_p2) begin
            sel    <= grant;
            rr_ptr <= grant;
            state  <= LOAD;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (score_ovf(sel_score)) begin
            state   <= WR_TENS;
            wr_en   <= 1'b1;
            wr_addr <= base_sel;
            wr_data <= ASCII_DASH;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            state   <= WR_TENS;
            wr_en   <= 1'b1;
            wr_addr <= base_sel;
            wr_data <= tens_char(div_tens);
          end
        end
        WR_TENS: begin
          if (wr_ready) begin
            state   <= WR_ONES;
            wr_addr <= base_sel + ONES_OFS;
            wr_data <= div_ovf ? ASCII_DASH : digit_char(div_ones);
          end
        end
        WR_ONES: begin
          if (wr_ready) begin
            state <= IDLE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          wr_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_text_scheduler.sv
// Scoreboard bench for score_text_scheduler: stimulus pushes the expected
// buffer writes (computed with decimal arithmetic) and a monitor pops and
// compares every accepted write.
module tb_score_text_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] score_p1, score_p2;
  logic       wr_en, wr_ready, busy;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;

  always #5 clk = ~clk;

  score_text_scheduler #(
    .ADDR_W       (8),
    .BASE_ADDR_P1 (8'h00),
    .BASE_ADDR_P2 (8'h10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .score_p1 (score_p1),
    .score_p2 (score_p2),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [6:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int  m_rr = 0;         // player served most recently (0 = P1, 1 = P2)

  function automatic logic [6:0] exp_tens(input int s);
    if (s >= 100) return 7'h2D;
`ifdef SCORE_TEXT_BLANK_LEADING_ZERO_EN
    if (s / 10 == 0) return 7'h20;
`endif
    return 7'h30 + 7'(s / 10);
  endfunction

  function automatic logic [6:0] exp_ones(input int s);
    if (s >= 100) return 7'h2D;
    return 7'h30 + 7'(s % 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_player(input int p, input int s);
    wr_t w;
    logic [7:0] base;
    base = (p == 1) ? 8'h10 : 8'h00;
    w.addr = base;        w.data = exp_tens(s); exp_q.push_back(w);
    w.addr = base + 8'd1; w.data = exp_ones(s); exp_q.push_back(w);
    m_rr = p;
  endtask

  // Both players changed together: the one not served last goes first.
  task automatic push_both(input int s1, input int s2);
    if (m_rr == 0) begin
      push_player(1, s2); push_player(0, s1);
    end else begin
      push_player(0, s1); push_player(1, s2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) quiet++;
      else quiet = 0;
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);
    chk({name, "_drain_busy"}, busy, 0);
  endtask

  task automatic wait_wr_en(input string name);
    int n = 0;
    while (!wr_en && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_wr_en_seen"}, wr_en, 1);
  endtask

  // Ready driver.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = ($urandom_range(0, 3) != 0);
      default: wr_ready = 1'b0;
    endcase
  end

  // Monitor: checks stall stability and every accepted write.
  logic       hold_prev = 1'b0;
  logic [7:0] prev_addr;
  logic [6:0] prev_data;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("stall_wr_en", wr_en, 1);
        chk("stall_wr_addr", wr_addr, prev_addr);
        chk("stall_wr_data", wr_data, prev_data);
      end
      hold_prev = wr_en && !wr_ready;
      prev_addr = wr_addr;
      prev_data = wr_data;
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int v1, v2, mode;
    int edge_vals[5] = '{9, 10, 100, 255, 0};

    rst = 1'b1; score_p1 = 8'd0; score_p2 = 8'd0; wr_ready = 1'b1;
    repeat (3) tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 7'h30);

    // Both players pend out of reset; P2 is served first.
    rst = 1'b0;
    push_player(1, 0);
    push_player(0, 0);
    drain("post_reset");

    // 0 -> 47: LOAD + 5 DIV + 2 writes of busy.
    score_p1 = 8'd47;
    push_player(0, 47);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) cnt++;
    end
    chk("busy_cycles_47", cnt, 8);
    drain("score47");

    // Overflow score shows dashes.
    score_p2 = 8'd150;
    push_player(1, 150);
    drain("score150");

    // Make P1 the last served, then change both together.
    score_p1 = 8'd3;
    push_player(0, 3);
    drain("score3");
    score_p1 = 8'd12; score_p2 = 8'd99;
    push_both(12, 99);
    drain("simul");

    // Stall during the tens write of score 8.
    ready_mode = 2; wr_ready = 1'b0;
    score_p1 = 8'd8;
    push_player(0, 8);
    wait_wr_en("stall8");
    for (int i = 0; i < 5; i++) begin
      chk("stall8_en", wr_en, 1);
      chk("stall8_addr", wr_addr, 8'h00);
      chk("stall8_data", wr_data, exp_tens(8));
      tick();
    end
    ready_mode = 0;
    drain("stall8");

    // Score changes while its old value is being written.
    score_p1 = 8'd20;
    push_player(0, 20);
    wait_wr_en("midop");
    score_p1 = 8'd21;
    push_player(0, 21);
    drain("midop");

    // Reset in the middle of a division.
    score_p1 = 8'd99;
    repeat (5) tick();
    chk("div_busy_before_rst", busy, 1);
    rst = 1'b1;
    tick();
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    m_rr = 0;
    push_both(99, int'(score_p2));
    drain("midrst");

    // Single digit (blank-tens case when the macro is defined).
    score_p1 = 8'd5;
    push_player(0, 5);
    drain("score5");

    // Digit boundaries and overflow values on P2.
    for (int i = 0; i < 5; i++) begin
      score_p2 = 8'(edge_vals[i]);
      push_player(1, edge_vals[i]);
      drain("edge");
    end

    // Randomised changes with random back-pressure.
    ready_mode = 1;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      do v1 = $urandom_range(0, 130); while (v1 == int'(score_p1));
      do v2 = $urandom_range(0, 130); while (v2 == int'(score_p2));
      if (mode == 0) begin
        score_p1 = 8'(v1); push_player(0, v1);
      end else if (mode == 1) begin
        score_p2 = 8'(v2); push_player(1, v2);
      end else begin
        score_p1 = 8'(v1); score_p2 = 8'(v2); push_both(v1, v2);
      end
      drain("random");
    end
    ready_mode = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
